// File: rtl/uc_jogo_multijogador.sv
// Turn-based control unit for a multiplayer asteroid game: lives, turn rotation, winner detection.
// Optional per-move timeout is built when UC_JOGO_TIMEOUT_EN is defined.
module uc_jogo_multijogador #(
    parameter int N_JOGADORES    = 2,
    parameter int VIDAS_INICIAIS = 3,
    parameter int W_VIDAS        = 3,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           ocorreu_jogada,
    input  logic                           ocorreu_tiro,
    input  logic                           fim_movimentacao_asteroides_e_tiros,
    input  logic                           fim_registra_tiros,
    input  logic                           perdeu_vida,
    output logic                           enable_reg_jogada,
    output logic                           reset_reg_jogada,
    output logic                           inicia_registra_tiros,
    output logic                           inicia_movimentacao_asteroides_e_tiros,
    output logic                           reset_maquinas,
    output logic                           pronto,
    output logic                           vencedor_valido,
    output logic [2:0]                     jogador_atual,
    output logic [2:0]                     vencedor,
    output logic [N_JOGADORES*W_VIDAS-1:0] vidas_jogadores,
    output logic [4:0]                     db_estado_jogo_principal
);

    if (N_JOGADORES < 1 || N_JOGADORES > 8 || W_VIDAS < 1 || TIMEOUT_CICLOS < 1) begin : g_param_invalido
        $error("uc_jogo_multijogador: parameter out of range");
    end

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        INICIALIZA       = 4'h1,
        ESPERA_JOGADA    = 4'h2,
        REGISTRA_JOGADA  = 4'h3,
        TERMINA_MOV      = 4'h4,
        ESPERA_REG_TIROS = 4'h5,
        FIM_JOGO         = 4'h6,
        INICIA_REG_TIROS = 4'h7,
        TROCA_JOGADOR    = 4'h8,
        ERRO             = 4'hF
    } estado_t;

    estado_t              estado, prox_estado;
    logic [W_VIDAS-1:0]   vidas [8];
    logic [7:0]           vivo;
    logic [3:0]           n_vivos;
    logic                 fim;
    logic [2:0]           menor_vivo;
    logic [2:0]           prox_jogador;
    logic                 achou;
    logic [2:0]           idx;
    logic                 pode_perder;
    logic                 estourou;

    // Entries at or above N_JOGADORES are never loaded, so they always read as dead.
    always_comb begin
        vivo    = '0;
        n_vivos = '0;
        for (int i = 0; i < 8; i++) begin
            vivo[i] = (vidas[i] != '0);
            n_vivos = n_vivos + 4'(vivo[i]);
        end
        fim = (n_vivos == 4'd0) || ((N_JOGADORES > 1) && (n_vivos == 4'd1));
    end

    always_comb begin
        menor_vivo = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vivo[i]) menor_vivo = 3'(i);
        end
    end

    // Cyclic scan starting after the current player; keeps the current one if nobody else lives.
    always_comb begin
        prox_jogador = jogador_atual;
        achou        = 1'b0;
        idx          = '0;
        for (int k = 1; k < N_JOGADORES; k++) begin
            idx = 3'((int'(jogador_atual) + k) % N_JOGADORES);
            if (!achou && vivo[idx]) begin
                prox_jogador = idx;
                achou        = 1'b1;
            end
        end
    end

    assign pode_perder = (estado == ESPERA_JOGADA)   || (estado == REGISTRA_JOGADA)  ||
                         (estado == TERMINA_MOV)     || (estado == ESPERA_REG_TIROS) ||
                         (estado == INICIA_REG_TIROS) || (estado == TROCA_JOGADOR);

`ifdef UC_JOGO_TIMEOUT_EN
    localparam int W_CONT = $clog2(TIMEOUT_CICLOS) + 1;
    logic [W_CONT-1:0] contador;

    // Every entry into ESPERA_JOGADA comes from another state, so the count starts at zero.
    always_ff @(posedge clock) begin
        if (reset || estado != ESPERA_JOGADA) contador <= '0;
        else                                  contador <= contador + W_CONT'(1);
    end
    assign estourou = (contador == W_CONT'(TIMEOUT_CICLOS - 1));
`else
    assign estourou = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL:          if (iniciar) prox_estado = INICIALIZA;
            INICIALIZA:       prox_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (fim)                       prox_estado = FIM_JOGO;
                else if (!vivo[jogador_atual]) prox_estado = TROCA_JOGADOR;
                else if (ocorreu_jogada)       prox_estado = REGISTRA_JOGADA;
                else if (estourou)             prox_estado = TROCA_JOGADOR;
            end
            REGISTRA_JOGADA: begin
                if (fim)               prox_estado = FIM_JOGO;
                else if (ocorreu_tiro) prox_estado = TERMINA_MOV;
                else                   prox_estado = TROCA_JOGADOR;
            end
            TERMINA_MOV:      if (fim_movimentacao_asteroides_e_tiros)
                                  prox_estado = fim ? FIM_JOGO : INICIA_REG_TIROS;
            INICIA_REG_TIROS: prox_estado = ESPERA_REG_TIROS;
            ESPERA_REG_TIROS: if (fim_registra_tiros) prox_estado = TROCA_JOGADOR;
            TROCA_JOGADOR:    prox_estado = fim ? FIM_JOGO : ESPERA_JOGADA;
            FIM_JOGO:         if (iniciar) prox_estado = INICIALIZA;
            ERRO:             prox_estado = ERRO;
            default:          prox_estado = ERRO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) vidas[i] <= '0;
            jogador_atual <= '0;
        end else begin
            if (estado == INICIALIZA) begin
                for (int i = 0; i < 8; i++)
                    vidas[i] <= (i < N_JOGADORES) ? W_VIDAS'(VIDAS_INICIAIS) : '0;
            end else if (perdeu_vida && pode_perder && vidas[jogador_atual] != '0) begin
                vidas[jogador_atual] <= vidas[jogador_atual] - W_VIDAS'(1);
            end
            if (estado == INICIALIZA)         jogador_atual <= '0;
            else if (estado == TROCA_JOGADOR) jogador_atual <= prox_jogador;
        end
    end

    always_comb begin
        vidas_jogadores = '0;
        for (int i = 0; i < N_JOGADORES; i++)
            vidas_jogadores[i*W_VIDAS +: W_VIDAS] = vidas[i];
    end

    always_comb begin
        enable_reg_jogada                      = 1'b0;
        reset_reg_jogada                       = 1'b0;
        inicia_registra_tiros                  = 1'b0;
        inicia_movimentacao_asteroides_e_tiros = 1'b0;
        reset_maquinas                         = 1'b0;
        pronto                                 = 1'b0;
        vencedor_valido                        = 1'b0;
        vencedor                               = '0;
        db_estado_jogo_principal               = {1'b0, estado};
        case (estado)
            INICIALIZA: begin
                reset_reg_jogada = 1'b1;
                reset_maquinas   = 1'b1;
            end
            ESPERA_JOGADA:    inicia_movimentacao_asteroides_e_tiros = 1'b1;
            REGISTRA_JOGADA:  enable_reg_jogada = 1'b1;
            INICIA_REG_TIROS: inicia_registra_tiros = 1'b1;
            FIM_JOGO: begin
                pronto           = 1'b1;
                reset_reg_jogada = 1'b1;
                reset_maquinas   = 1'b1;
                if (n_vivos == 4'd1) begin
                    vencedor_valido = 1'b1;
                    vencedor        = menor_vivo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/uc_jogo_multijogador.md
UC_JOGO_MULTIJOGADOR -- requirements
Module: uc_jogo_multijogador

Interface
REQ-001 SHALL have parameter N_JOGADORES, default 2, number of players taking turns (1..8).
REQ-002 SHALL have parameter VIDAS_INICIAIS, default 3, lives loaded per player at game start (1..2^W_VIDAS-1).
REQ-003 SHALL have parameter W_VIDAS, default 3, width of each player's life counter.
REQ-004 SHALL have parameter TIMEOUT_CICLOS, default 1000, cycles allowed per move before turn is forfeited.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have inputs, 1 bit each: iniciar (start/restart game); ocorreu_jogada (move available); ocorreu_tiro (registered move is a shot); fim_movimentacao_asteroides_e_tiros (done pulse); fim_registra_tiros (done pulse); perdeu_vida (collision pulse for current player).
REQ-007 SHALL have 1-bit outputs: enable_reg_jogada, reset_reg_jogada, inicia_registra_tiros, inicia_movimentacao_asteroides_e_tiros, reset_maquinas, pronto, vencedor_valido.
REQ-008 SHALL have outputs: jogador_atual  out  3  current player index; vencedor  out  3  winner index; vidas_jogadores  out  N_JOGADORES*W_VIDAS  life counters, player i at bits [i*W_VIDAS +: W_VIDAS]; db_estado_jogo_principal  out  5  state code.

Function
REQ-009 SHALL be a Moore FSM; codes: INICIAL 0, INICIALIZA 1, ESPERA_JOGADA 2, REGISTRA_JOGADA 3, TERMINA_MOV 4, ESPERA_REG_TIROS 5, FIM_JOGO 6, INICIA_REG_TIROS 7, TROCA_JOGADOR 8, ERRO F; db_estado_jogo_principal equals current code.
REQ-010 SHALL transition INICIAL->INICIALIZA on iniciar; INICIALIZA->ESPERA_JOGADA unconditionally.
REQ-011 SHALL, in INICIALIZA, load every life counter with VIDAS_INICIAIS, set jogador_atual=0, clear timeout counter, assert reset_reg_jogada and reset_maquinas.
REQ-012 SHALL define fim = (alive count == 0) or (N_JOGADORES>1 and alive count == 1); alive = life counter != 0.
REQ-013 SHALL, in ESPERA_JOGADA, REGISTRA_JOGADA, TERMINA_MOV (only when its done pulse is high) and TROCA_JOGADOR, go to FIM_JOGO when fim is true; this check has top priority.
REQ-014 SHALL, in ESPERA_JOGADA: current player's lives==0 -> TROCA_JOGADOR; else ocorreu_jogada -> REGISTRA_JOGADA; else stay; assert inicia_movimentacao_asteroides_e_tiros.
REQ-015 SHALL, in REGISTRA_JOGADA, assert enable_reg_jogada for one cycle; ocorreu_tiro -> TERMINA_MOV, else -> TROCA_JOGADOR.
REQ-016 SHALL hold TERMINA_MOV until fim_movimentacao_asteroides_e_tiros, then -> INICIA_REG_TIROS (one cycle, asserts inicia_registra_tiros) -> ESPERA_REG_TIROS; fim_registra_tiros -> TROCA_JOGADOR.
REQ-017 SHALL, in TROCA_JOGADOR (one cycle), set jogador_atual to first alive index scanning cyclically from jogador_atual+1 (wrap at N_JOGADORES); unchanged if no other player alive; then -> ESPERA_JOGADA.
REQ-018 SHALL decrement the current player's counter on perdeu_vida in states 2,3,4,5,7,8, saturating at 0; ignored in 0,1,6,F; takes effect the following cycle regardless of a simultaneous state change.
REQ-019 SHALL, in FIM_JOGO, assert pronto, reset_reg_jogada, reset_maquinas; vencedor_valido=1 and vencedor=lowest alive index if exactly one alive, else vencedor_valido=0, vencedor=0; iniciar -> INICIALIZA.
REQ-020 SHALL go to ERRO on any unused code; ERRO holds until reset, all control outputs 0.

Reset
REQ-021 SHALL, on reset high at a rising edge, enter INICIAL from any state including mid-turn, clear life counters, jogador_atual, vencedor, timeout counter.
REQ-022 SHALL drive all 1-bit outputs 0 in INICIAL, db_estado_jogo_principal=0.

Configuration
REQ-023 SHALL, with UC_JOGO_TIMEOUT_EN defined, count cycles in ESPERA_JOGADA (cleared on entry) and go to TROCA_JOGADOR when count reaches TIMEOUT_CICLOS-1 without ocorreu_jogada; ocorreu_jogada that same cycle wins.
REQ-024 SHALL, without UC_JOGO_TIMEOUT_EN, omit the counter; ESPERA_JOGADA waits indefinitely.

Verification
REQ-025 SHALL cover: reset, iniciar -> INICIALIZA then state 2, vidas_jogadores = {3,3}, jogador_atual=0.
REQ-026 SHALL cover: move with ocorreu_tiro=1, both done pulses -> states 3,4,7,5,8,2; jogador_atual 0->1.
REQ-027 SHALL cover: N=3, player 1 at 0 lives, turn ends at player 0 -> jogador_atual=2 (skip).
REQ-028 SHALL cover: three perdeu_vida pulses on player 1, N=2 -> FIM_JOGO, pronto=1, vencedor=0, vencedor_valido=1; fourth pulse leaves counter at 0.
REQ-029 SHALL cover: UC_JOGO_TIMEOUT_EN, TIMEOUT_CICLOS=10, no move -> TROCA_JOGADOR after exactly 10 cycles in state 2; undefined -> stays in 2.
REQ-030 SHALL cover: reset asserted in TERMINA_MOV -> INICIAL next cycle, all outputs 0.
